// File: rtl/if_module.sv
// Instruction-fetch stage: fetch PC, instruction-ROM handshake, IF/ID pipeline
// register with stall, redirect, a one-entry skid buffer and stale-fetch kill.
module if_module #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        irom_req,
    output logic [31:0] irom_addr,
    input  logic        irom_ack,
    input  logic [31:0] irom_rdata,
    output logic [31:0] pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_KILL
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pend;
    logic [31:0] w_pend_nxt;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc;
    logic        w_buf_load;
    logic        r_id_valid;
    logic [31:0] r_id_inst;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic        w_id_load;
    logic [31:0] w_id_ld_inst;
    logic [31:0] w_id_ld_pc;
    logic [31:0] w_target;

    assign w_target  = redirect_pc & ~32'd3;
    assign irom_req  = !rst_n && (r_state != S_HOLD);
    assign irom_addr = r_pc;
    assign pc        = r_pc;
    assign id_valid  = r_id_valid;
    assign id_inst   = r_id_inst;
    assign id_pc     = r_id_pc;
    assign id_pc4    = r_id_pc4;

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pend_nxt   = r_pend;
        w_buf_load   = 1'b0;
        w_id_load    = 1'b0;
        w_id_ld_inst = irom_rdata;
        w_id_ld_pc   = r_pc;
        case (r_state)
            S_REQ: begin
                if (redirect) begin
                    if (irom_ack) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pend_nxt  = w_target;
                        w_state_nxt = S_KILL;
                    end
                end else if (irom_ack) begin
                    if (!stall || !r_id_valid) begin
                        w_id_load = 1'b1;
                        w_pc_nxt  = r_pc + 32'd4;
                    end else begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_id_load    = 1'b1;
                    w_id_ld_inst = r_buf_inst;
                    w_id_ld_pc   = r_buf_pc;
                    w_pc_nxt     = r_buf_pc + 32'd4;
                    w_state_nxt  = S_REQ;
                end
            end
            S_KILL: begin
                // The stale request stays on the bus until acked; a redirect
                // arriving with that ack goes straight to the newest target.
                if (irom_ack) begin
                    w_pc_nxt    = redirect ? w_target : r_pend;
                    w_state_nxt = S_REQ;
                end else if (redirect) begin
                    w_pend_nxt = w_target;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_pend     <= '0;
            r_buf_inst <= NOP_INST;
            r_buf_pc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            if (w_buf_load) begin
                r_buf_inst <= irom_rdata;
                r_buf_pc   <= r_pc;
            end
        end
    end

    // Without a delivery, a stalled IF/ID holds; otherwise it drains to a bubble
    // (id_pc/id_pc4 keep their last values).
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP_INST;
            r_id_pc    <= '0;
            r_id_pc4   <= '0;
        end else if (w_id_load) begin
            r_id_valid <= 1'b1;
            r_id_inst  <= w_id_ld_inst;
            r_id_pc    <= w_id_ld_pc;
            r_id_pc4   <= w_id_ld_pc + 32'd4;
        end else if (redirect || !stall) begin
            r_id_valid <= 1'b0;
            r_id_inst  <= NOP_INST;
        end
    end

endmodule

// File: doc/if_module.md
Name: if_module

Overview:
- Instruction-fetch stage for the pipelined CPU variant. It sits directly upstream of the decode stage, which consumes `id_inst`, `id_pc` and `id_pc4`.
- Owns the fetch PC register and the request/acknowledge handshake to instruction ROM.
- Owns the IF/ID pipeline register, with stall and redirect (flush) control.
- Tolerates variable ROM latency and discards fetches made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) presented to decode when invalid.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous reset, active-high (asserted when 1).
- stall  input  1  hazard unit: decode cannot accept; IF/ID must hold.
- redirect  input  1  control-flow change (branch taken / jal / jalr) resolved downstream.
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 00).
- irom_req  output  1  fetch request to instruction ROM.
- irom_addr  output  32  fetch address; stable while irom_req=1 and no ack.
- irom_ack  input  1  ROM has data this cycle; may be high in the same cycle as req.
- irom_rdata  input  32  instruction word, valid when irom_ack=1.
- pc  output  32  current fetch PC (equals irom_addr).
- id_valid  output  1  IF/ID holds a real instruction.
- id_inst  output  32  IF/ID instruction word to decode.
- id_pc  output  32  PC of id_inst.
- id_pc4  output  32  id_pc+4, feeds decode write-back mux for jal/jalr link.

Behaviour:

Reset (async, while rst_n=1):
- pc=RESET_PC, state=S_REQ, kill=0.
- irom_req=0, id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc4=0.
- irom_req is gated low during reset. The first cycle after release drives irom_req=1, irom_addr=RESET_PC.
- Reset mid-operation abandons any outstanding fetch; the ROM must tolerate a dropped request.

States:
- S_REQ
  - irom_req=1, irom_addr=pc.
  - On irom_ack with kill=0 and (stall=0 or id_valid=0): load IF/ID with id_inst=irom_rdata, id_pc=pc, id_pc4=pc+4, id_valid=1. Then pc<=pc+4 and stay in S_REQ (back-to-back; 1 instr/cycle when ack is tied high).
  - On irom_ack with kill=0, stall=1 and id_valid=1: capture rdata and pc in a skid buffer, go to S_HOLD.
- S_HOLD
  - irom_req=0; buffer full.
  - When stall=0: move the buffer into IF/ID, pc<=buf_pc+4, go to S_REQ.
- S_KILL
  - irom_req=1, irom_addr=stale address (held until ack; the bus requires completion).
  - On irom_ack: discard data, pc<=pending target, go to S_REQ.

Redirect (highest priority, overrides stall):
- Next cycle id_valid=0, id_inst=NOP_INST.
- In S_REQ with no ack this cycle: latch the target into a pending register and go to S_KILL.
- In S_REQ with ack this cycle: discard data, pc<=redirect_pc, stay in S_REQ.
- In S_HOLD: drop the buffer, pc<=redirect_pc, go to S_REQ.
- In S_KILL: overwrite the pending target; remain in S_KILL.

IF/ID when no instruction is delivered:
- stall=1: hold all IF/ID outputs unchanged.
- stall=0: id_valid<=0 and id_inst<=NOP_INST. id_pc and id_pc4 hold their values.

Arithmetic:
- All PC arithmetic is modulo 2^32. pc=32'hFFFF_FFFC wraps to 0 silently.

Latency:
- With ack in the same cycle as req, an instruction fetched in cycle N appears at IF/ID in cycle N+1.
- With redirect in cycle N, the first fetch of the target is requested in cycle N+1 (if no kill is needed), and its instruction reaches IF/ID in cycle N+2.

Test Plan:
- Reset release, irom_ack tied 1, ROM[0]=32'h00500093, ROM[4]=32'h00A00113 -> cycle 1: id_valid=1, id_inst=00500093, id_pc=0, id_pc4=4; cycle 2: id_inst=00A00113, id_pc=4; one instruction per cycle thereafter.
- ROM ack after 3 wait cycles -> irom_addr held at 0x8 for all 4 req cycles; id_valid=0 with id_inst=NOP_INST during the wait; one valid instruction at id_pc=0x8.
- stall=1 for 2 cycles while the ack for 0xC arrives -> IF/ID holds the 0x8 instruction; FSM enters S_HOLD with irom_req=0; after stall drops, the next cycle shows id_pc=0xC, then the fetch of 0x10 begins.
- redirect=1, redirect_pc=0x100 with ack in the same cycle -> data discarded; next cycle id_valid=0 and irom_addr=0x100; following cycle id_pc=0x100.
- redirect=1, redirect_pc=0x203 (misaligned) during an outstanding un-acked fetch of 0x20 -> S_KILL keeps addr 0x20 until ack, its data never reaches IF/ID; then irom_addr=0x200.
- Second redirect to 0x300 while in S_KILL, then pc=0xFFFFFFFC fetched -> fetch resumes at 0x300 only; separately, pc wraps to 0x0 with id_pc4=0x0.
- Assert rst_n mid-S_KILL -> outputs immediately return to reset values; the first request after release is to RESET_PC.
